// File: rtl/led_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_sched_pkg
// Brief    : Shared types and constants for the LED blink-code scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package led_sched_pkg;

  localparam int CODE_W  = 4;
  localparam int GRANT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ON   = 3'd1,
    ST_OFF  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Clock cycles per millisecond tick.
  function automatic int ms_cycles(input int clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_sched_ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ms_tick_gen
// Brief    : Millisecond prescaler; one-cycle tick on the terminal count,
//            restartable so a new grant begins on an exact ms boundary.
// Revision : 1.0 - initial release
// ============================================================================
module ms_tick_gen
  import led_sched_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic CLK_50M,
  input  logic RST_N,
  input  logic clear,
  output logic tick
);

  localparam int              c_period = ms_cycles(CLK_FREQ);
  localparam int              c_cnt_w  = (c_period > 1) ? $clog2(c_period) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_period - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/led_blink_sched.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_sched
// Brief    : Shares one LED between N_REQ requesters, playing each granted
//            0..15 blink code followed by a gap, then acknowledging.
//            Define LED_BLINK_SCHED_RR_EN for round-robin arbitration;
//            otherwise the lowest requesting index wins.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int N_REQ    = 4,
  parameter int ON_MS    = 200,
  parameter int OFF_MS   = 200,
  parameter int GAP_MS   = 1000
) (
  input  logic                      CLK_50M,
  input  logic                      RST_N,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [CODE_W*N_REQ-1:0]   CODE,
  output logic [N_REQ-1:0]          ACK,
  output logic                      BUSY,
  output logic [GRANT_W-1:0]        GRANT_ID,
  output logic                      LED1
);

  localparam logic [2:0] c_st_idle = ST_IDLE;
  localparam logic [2:0] c_st_on   = ST_ON;
  localparam logic [2:0] c_st_off  = ST_OFF;
  localparam logic [2:0] c_st_gap  = ST_GAP;
  localparam logic [2:0] c_st_done = ST_DONE;

  localparam int c_ph_max = (ON_MS > OFF_MS) ?
                            ((ON_MS  > GAP_MS) ? ON_MS  : GAP_MS) :
                            ((OFF_MS > GAP_MS) ? OFF_MS : GAP_MS);
  localparam int c_ph_w   = $clog2(c_ph_max + 1);
  localparam logic [c_ph_w-1:0] c_on_last  = c_ph_w'(ON_MS - 1);
  localparam logic [c_ph_w-1:0] c_off_last = c_ph_w'(OFF_MS - 1);
  localparam logic [c_ph_w-1:0] c_gap_last = c_ph_w'(GAP_MS - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_ph_w-1:0]    r_phase;
  logic [CODE_W-1:0]    r_remain;
  logic [CODE_W-1:0]    w_win_code;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   w_win;
  logic [N_REQ-1:0]     r_ack;
  logic                 r_busy;
  logic                 r_led;
  logic                 w_any;
  logic                 w_req_g;
  logic                 w_tick;
  logic                 w_clear;
  logic                 w_abort;
  logic                 w_ack_any;
  logic                 w_ph_done;
  logic                 w_playing;

`ifdef LED_BLINK_SCHED_RR_EN
  logic [GRANT_W-1:0]   r_rr_ptr;
  logic [GRANT_W:0]     w_idx;
`endif

  assign w_any     = |REQ;
  assign w_ack_any = |r_ack;
  assign w_clear   = (r_state == c_st_idle) && w_any;
  assign w_playing = (r_state == c_st_on) || (r_state == c_st_off) ||
                     (r_state == c_st_gap);
  assign w_abort   = w_playing && !w_req_g;

  ms_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .CLK_50M (CLK_50M),
    .RST_N   (RST_N),
    .clear   (w_clear),
    .tick    (w_tick)
  );

  // Arbitration, plus lookup of the winner's code and the grantee's request.
  always_comb begin
    w_win      = '0;
    w_win_code = '0;
    w_req_g    = 1'b0;
`ifdef LED_BLINK_SCHED_RR_EN
    w_idx      = '0;
    // Descending walk so the candidate nearest the pointer is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (GRANT_W+1)'(k);
      if (w_idx >= (GRANT_W+1)'(N_REQ)) begin
        w_idx = w_idx - (GRANT_W+1)'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (REQ[i] && (w_idx == (GRANT_W+1)'(i))) begin
          w_win = GRANT_W'(i);
        end
      end
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        w_win = GRANT_W'(i);
      end
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == GRANT_W'(i)) begin
        w_win_code = CODE[CODE_W*i +: CODE_W];
      end
      if (r_grant == GRANT_W'(i)) begin
        w_req_g = REQ[i];
      end
    end
  end

  always_comb begin
    w_ph_done = 1'b0;
    if (w_tick) begin
      case (r_state)
        c_st_on:  w_ph_done = (r_phase == c_on_last);
        c_st_off: w_ph_done = (r_phase == c_off_last);
        c_st_gap: w_ph_done = (r_phase == c_gap_last);
        default:  w_ph_done = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_any) begin
          w_state_nxt = (w_win_code == '0) ? c_st_done : c_st_on;
        end
      end
      c_st_on: begin
        if (w_abort) begin
          w_state_nxt = c_st_idle;
        end else if (w_ph_done) begin
          w_state_nxt = (r_remain == CODE_W'(1)) ? c_st_gap : c_st_off;
        end
      end
      c_st_off: begin
        if (w_abort) begin
          w_state_nxt = c_st_idle;
        end else if (w_ph_done) begin
          w_state_nxt = c_st_on;
        end
      end
      c_st_gap: begin
        if (w_abort) begin
          w_state_nxt = c_st_idle;
        end else if (w_ph_done) begin
          w_state_nxt = c_st_done;
        end
      end
      // DONE spans two cycles: one to raise ACK, one while it is visible.
      c_st_done: begin
        if (w_ack_any) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= c_st_idle;
      r_busy   <= 1'b0;
      r_led    <= 1'b0;
      r_phase  <= '0;
      r_remain <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != c_st_idle);
      r_led   <= (w_state_nxt == c_st_on);

      if (w_state_nxt != r_state) begin
        r_phase <= '0;
      end else if (w_tick) begin
        r_phase <= r_phase + 1'b1;
      end

      if (w_clear) begin
        r_grant  <= w_win;
        r_remain <= w_win_code;
      end else if ((r_state == c_st_on) && w_ph_done && !w_abort) begin
        r_remain <= r_remain - 1'b1;
      end

      r_ack <= '0;
      if ((r_state == c_st_done) && !w_ack_any) begin
        r_ack <= N_REQ'(1) << r_grant;
      end
    end
  end

`ifdef LED_BLINK_SCHED_RR_EN
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_rr_ptr <= '0;
    end else if (w_abort || ((r_state == c_st_done) && w_ack_any)) begin
      r_rr_ptr <= (r_grant == GRANT_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end
`endif

  assign ACK      = r_ack;
  assign BUSY     = r_busy;
  assign GRANT_ID = r_grant;
  assign LED1     = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_sched
// Brief    : Self-checking bench for led_blink_sched against a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_blink_sched;

  localparam int CLK_FREQ = 4000;
  localparam int T        = CLK_FREQ / 1000;
  localparam int ON_MS    = 2;
  localparam int OFF_MS   = 1;
  localparam int GAP_MS   = 3;
`ifdef LED_BLINK_SCHED_RR_EN
  localparam bit RR_MODE  = 1'b1;
`else
  localparam bit RR_MODE  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] code = '0;
  logic [3:0]  ack;
  logic        busy;
  logic [2:0]  grant_id;
  logic        led1;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  led_blink_sched #(
    .CLK_FREQ (CLK_FREQ),
    .N_REQ    (4),
    .ON_MS    (ON_MS),
    .OFF_MS   (OFF_MS),
    .GAP_MS   (GAP_MS)
  ) dut (
    .CLK_50M  (clk),
    .RST_N    (rst_n),
    .REQ      (req),
    .CODE     (code),
    .ACK      (ack),
    .BUSY     (busy),
    .GRANT_ID (grant_id),
    .LED1     (led1)
  );

  always #5 clk = ~clk;

  // LED level s cycles after the rise for a code-n sequence.
  function automatic logic led_model(input int n, input int s);
    int burst;
    burst = (n == 0) ? 0 : (n * ON_MS + (n - 1) * OFF_MS) * T;
    if (s < 0 || s >= burst) return 1'b0;
    return ((s % ((ON_MS + OFF_MS) * T)) < ON_MS * T);
  endfunction

  function automatic int seq_len(input int n);
    return (n == 0) ? 0 : (n * ON_MS + (n - 1) * OFF_MS + GAP_MS) * T;
  endfunction

  function automatic int pick(input logic [3:0] r, input int ptr);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = ((RR_MODE ? ptr : 0) + k) % 4;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  // Entered at a negedge of an IDLE cycle with the request already driven.
  // mode: 0 drop own REQ at ACK, 1 keep it, 2 drop every REQ.
  task automatic serve(input int exp_id, input int exp_code, input int mode, output int ack_s);
    int   len;
    logic exp_led;
    logic [3:0] exp_ack;
    len   = seq_len(exp_code);
    ack_s = -1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (grant_id !== 3'(exp_id)) begin
      n_err++;
      $display("FAIL grant_id: got %0d expected %0d", grant_id, exp_id);
    end
    for (int i = 0; i < 4; i++) code[4*i +: 4] = 4'($urandom_range(0, 3));
    for (int s = 0; s <= len + 1; s++) begin
      if (s > 0) @(negedge clk);
      exp_led = led_model(exp_code, s);
      exp_ack = (s == len + 1) ? 4'(1 << exp_id) : 4'b0;
      n_vec++;
      if (led1 !== exp_led) begin
        n_err++;
        $display("FAIL led1 code%0d s=%0d: got %b expected %b", exp_code, s, led1, exp_led);
      end
      n_vec++;
      if (ack !== exp_ack || busy !== 1'b1) begin
        n_err++;
        $display("FAIL ack/busy code%0d s=%0d: got %b/%b expected %b/1", exp_code, s, ack, busy, exp_ack);
      end
      if (ack[exp_id] === 1'b1 && ack_s < 0) ack_s = s;
    end
    if (mode == 0) req[exp_id] = 1'b0;
    if (mode == 2) req = '0;
    m_ptr = (exp_id + 1) % 4;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_ack: busy=%b ack=%b expected 0/0000", busy, ack);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (led1 !== 1'b0) begin n_err++; $display("FAIL reset_led1: got %b expected 0", led1); end
    n_vec++;
    if (ack !== 4'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++;
    if (grant_id !== 3'd0) begin n_err++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_code3;
    int a;
    code[11:8] = 4'd3;
    req = 4'b0100;
    serve(pick(req, m_ptr), 3, 0, a);
    n_vec++;
    if (a !== 45) begin n_err++; $display("FAIL code3_ack_latency: got %0d expected 45", a); end
  endtask

  task automatic test_code0;
    int a;
    code[3:0] = 4'd0;
    req = 4'b0001;
    serve(pick(req, m_ptr), 0, 0, a);
    n_vec++;
    if (a !== 1) begin n_err++; $display("FAIL code0_ack_latency: got %0d expected 1", a); end
  endtask

  task automatic test_back_to_back;
    int a, id;
    code[7:4]   = 4'($urandom_range(1, 2));
    code[15:12] = 4'($urandom_range(1, 2));
    req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      id = pick(req, m_ptr);
      serve(id, int'(code[4*id +: 4]), (g == 2) ? 2 : 1, a);
    end
  endtask

  task automatic test_abort;
    int id;
    logic exp_led;
    code[3:0] = 4'd5;
    code[7:4] = 4'($urandom_range(1, 3));
    req = 4'b0011;
    id = pick(req, m_ptr);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (grant_id !== 3'(id)) begin n_err++; $display("FAIL abort_grant: got %0d expected %0d", grant_id, id); end
    // Second OFF phase spans s = 20..23; REQ drops inside it.
    for (int s = 0; s <= 21; s++) begin
      if (s > 0) @(negedge clk);
      exp_led = led_model(5, s);
      n_vec++;
      if (led1 !== exp_led || ack !== 4'b0) begin
        n_err++;
        $display("FAIL abort_play s=%0d: got led=%b ack=%b expected led=%b ack=0000", s, led1, ack, exp_led);
      end
    end
    req[id] = 1'b0;
    m_ptr = (id + 1) % 4;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || led1 !== 1'b0 || ack !== 4'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b led=%b ack=%b expected 0/0/0000", busy, led1, ack);
    end
    id = pick(req, m_ptr);
    serve(id, int'(code[4*id +: 4]), 0, id);
  endtask

  task automatic test_code15;
    int a;
    code[3:0] = 4'd15;
    req = 4'b0001;
    serve(pick(req, m_ptr), 15, 0, a);
    n_vec++;
    if (a !== 189) begin n_err++; $display("FAIL code15_ack_latency: got %0d expected 189", a); end
  endtask

  task automatic test_random;
    int id, a;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) code[4*i +: 4] = 4'($urandom_range(0, 3));
      req = 4'($urandom_range(1, 15));
      while (req != 4'b0) begin
        id = pick(req, m_ptr);
        serve(id, int'(code[4*id +: 4]), 0, a);
      end
    end
  endtask

  task automatic test_async_reset;
    code[15:12] = 4'd2;
    req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++;
    if (led1 !== 1'b1) begin n_err++; $display("FAIL areset_pre_led: got %b expected 1", led1); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (led1 !== 1'b0 || ack !== 4'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL areset_immediate: got led=%b ack=%b busy=%b expected 0/0000/0", led1, ack, busy);
    end
    req = '0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      n_vec++;
      if (ack !== 4'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL areset_after s=%0d: got ack=%b busy=%b expected 0000/0", s, ack, busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_code3;
    test_code0;
    test_back_to_back;
    test_abort;
    test_code15;
    test_random;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_blink_sched.md
# led_blink_sched

Blink-code scheduler that shares the single board LED between up to N_REQ status requesters. Each requester asks for a blink code of 0–15 pulses. The block arbitrates between requesters, plays the granted code as timed on/off pulses followed by an inter-code gap, then acknowledges. It sits between status-producing logic (error flags, link state, etc.) and the LED1 pin, and replaces free-running 1 s toggle logic wherever more than one source needs the LED.

## Interface
Parameters:
- CLK_FREQ, 50_000_000 — clock frequency in Hz; one ms tick = CLK_FREQ/1000 cycles.
- N_REQ, 4 — number of requesters (2..8).
- ON_MS, 200 — LED-on time per pulse, in ms.
- OFF_MS, 200 — LED-off time between pulses, in ms.
- GAP_MS, 1000 — LED-off time after the last pulse, before acknowledge, in ms.

Ports:
- CLK_50M  in  1  system clock.
- RST_N  in  1  reset; asynchronous, active-low; clock is CLK_50M.
- REQ  in  N_REQ  per-requester request level; held high until the matching ACK.
- CODE  in  4*N_REQ  blink count; requester i uses bits [4i+3:4i]; sampled at grant.
- ACK  out  N_REQ  one-cycle completion pulse to the granted requester.
- BUSY  out  1  high whenever state ≠ IDLE.
- GRANT_ID  out  3  index of the current/last granted requester.
- LED1  out  1  LED drive, active-high.

## Operation
- States: IDLE, ON, OFF, GAP, DONE. All outputs are registered.
- Reset values: state IDLE, LED1 0, ACK 0, BUSY 0, GRANT_ID 0, ms prescaler 0, phase counter 0, remaining-count 0, RR pointer 0.
- IDLE:
  - If any REQ bit is high, arbitrate and latch the winner index into GRANT_ID.
  - Latch the winner's CODE into the 4-bit remaining-count.
  - Clear the prescaler and the phase counter.
  - If the code is 0, go to DONE; otherwise go to ON.
- ON: LED1 = 1. After ON_MS ticks, decrement remaining-count. If it was 1, go to GAP; otherwise go to OFF.
- OFF: LED1 = 0. After OFF_MS ticks, go to ON.
- GAP: LED1 = 0. After GAP_MS ticks, go to DONE.
- DONE: ACK[GRANT_ID] = 1 for exactly one cycle, then go to IDLE.
- Abort: if REQ[GRANT_ID] drops while in ON, OFF or GAP:
  - Next cycle, go to IDLE with LED1 = 0.
  - No ACK is issued.
  - The pointer updates as for a completed grant.
- CODE changes after grant are ignored. Other requests are held pending and never preempt the current grant.
- Phase counter:
  - Width is clog2(max(ON_MS, OFF_MS, GAP_MS)+1).
  - It counts ms ticks, and is cleared on every state change.
  - A phase ends on the tick where counter == parameter−1.
- Prescaler:
  - Counts 0..CLK_FREQ/1000−1 and wraps to 0.
  - It asserts tick when it equals the terminal value.
  - It is cleared at grant, so the first phase is exact.

## Timing
- Grant happens in the first IDLE cycle with REQ high. LED1 rises on the following clock edge.
- Each phase lasts exactly param × CLK_FREQ/1000 cycles.
- Code-n duration from LED1 rise to ACK, where T = CLK_FREQ/1000:
  - (n·ON_MS + (n−1)·OFF_MS + GAP_MS)·T cycles, plus 1 cycle for DONE.
- Code 0: ACK 2 cycles after the grant cycle. LED1 stays 0.
- Back-to-back grants: ACK in cycle k, IDLE in cycle k+1, next grant in cycle k+1. A requester that keeps REQ high after its ACK re-enters arbitration at k+1.
- A requester must drop REQ in the cycle after ACK if it does not want a repeat.
- Reset mid-sequence: LED1 goes to 0 and ACK to 0 immediately (asynchronously). No ACK is issued after release.

## Configuration
- LED_BLINK_SCHED_RR_EN defined:
  - Round-robin arbitration. Search starts at index (last GRANT_ID+1) mod N_REQ.
  - The pointer updates on ACK or abort.
- Macro undefined: fixed priority, lowest index wins. The pointer logic is not compiled in.

## Structure
- Package led_sched_pkg holds:
  - the state enum (IDLE/ON/OFF/GAP/DONE);
  - CODE_W = 4 and GRANT_W = 3;
  - the function ms_cycles(CLK_FREQ).
- Sub-module ms_tick_gen holds the prescaler:
  - inputs: clear, with CLK_50M/RST_N;
  - output: a one-cycle tick.
- The arbiter and FSM live in the top module.

## Test plan
Bench uses CLK_FREQ=4000 (T=4 cycles), ON_MS=2, OFF_MS=1, GAP_MS=3.
- Reset → LED1=0, ACK=0, BUSY=0, GRANT_ID=0. Assert RST_N mid-ON → LED1 drops with no clock edge.
- REQ[2]=1 with CODE=3:
  - GRANT_ID=2; 3 LED pulses of 8 cycles each, separated by 4 cycles off, then a 12-cycle gap.
  - ACK[2] is a single pulse, 45 cycles after LED1 first rises.
- CODE=0 on REQ[0] → ACK[0] 2 cycles after grant; LED1 never rises.
- REQ[1] and REQ[3] held high continuously:
  - Fixed priority: grants go 1, 1, 1.
  - With LED_BLINK_SCHED_RR_EN: grants go 1, 3, 1.
  - Each grant starts in the cycle after the previous ACK.
- REQ[0] with CODE=5; drop REQ[0] in the second OFF phase → IDLE next cycle, LED1=0, no ACK; pending REQ[1] is granted.
- REQ[0] with CODE=15 → 15 pulses, ACK after 15·8 + 14·4 + 12 + 1 = 189 cycles from LED1 rise. This checks that remaining-count does not overflow.
